adder_rr_arbiter: RTL and testbench

ADDER_RR_ARBITER -- requirements
Module: adder_rr_arbiter

---
 rtl/adder_rr_arbiter_if.sv | 16 +
 rtl/adder_rr_arbiter.sv | 64 ++++++
 tb/tb_adder_rr_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/adder_rr_arbiter_if.sv
// adder_rr_arbiter_if: request/response bus between four requesters, the shared adder and its consumer
interface adder_rr_arbiter_if #(parameter int N = 16);
    logic [3:0]     req_valid;
    logic [4*N-1:0] req_a;
    logic [4*N-1:0] req_b;
    logic [3:0]     req_ready;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [N-1:0]   rsp_sum;
    logic           rsp_cout;
    logic           rsp_ready;
    modport master (output req_valid, req_a, req_b, rsp_ready,
                    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout);
    modport slave  (input  req_valid, req_a, req_b, rsp_ready,
                    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout);
endinterface

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: one ripple adder time-shared by four requesters under round-robin arbitration
module adder_rr_arbiter #(
    parameter int N    = 16,
    parameter int NREQ = 4
) (
    input logic              clk,
    input logic              rst_n,
    adder_rr_arbiter_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d, id_q, id_d, off, g;
    logic [N-1:0]      sum_q, sum_d, a, b, s;
    logic              cout_q, cout_d, en, xfer;
    logic [NREQ-1:0]   rot, grant;
    logic [2*NREQ-1:0] dbl;
    logic [N:1]        c;
    // req_ready is forced low while reset is held, not just after the flops clear
    always_comb begin
        en    = rst_n && (state_q == EMPTY || bus.rsp_ready);
        dbl   = {bus.req_valid, bus.req_valid} >> ptr_q;
        rot   = dbl[NREQ-1:0];
        off   = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        g     = ptr_q + off;
        xfer  = en && |bus.req_valid;
        grant = xfer ? 4'b1 << g : 4'b0;
        a     = bus.req_a[g*N +: N];
        b     = bus.req_b[g*N +: N];
    end
    assign s[0] = a[0] ^ b[0];
    assign c[1] = a[0] & b[0];
    genvar i;
    for (i = 1; i < N; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    always_comb begin
        state_d = xfer ? FULL : bus.rsp_ready ? EMPTY : state_q;
        ptr_d   = xfer ? g + 2'd1 : ptr_q;
        id_d    = xfer ? g : id_q;
        sum_d   = xfer ? s : sum_q;
        cout_d  = xfer ? c[N] : cout_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            id_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end
    assign bus.req_ready = grant;
    assign bus.rsp_valid = state_q == FULL;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb_adder_rr_arbiter: directed vectors plus a constrained random soak for the shared-adder arbiter
module tb_adder_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    adder_rr_arbiter_if #(.N(16)) bus();
    adder_rr_arbiter #(.N(16), .NREQ(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[i*16 +: 16] = a;
        bus.req_b[i*16 +: 16] = b;
    endtask
    task automatic rst_pulse();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask
    logic [1:0]  rr_ids [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] rr_sums[5] = '{16'h0011, 16'h0111, 16'h0211, 16'h0311, 16'h0011};
    initial begin
        logic [3:0]  v, rdy;
        logic [16:0] full;
        logic        ev, ecout;
        logic [1:0]  eid, gi;
        logic [15:0] esum;
        int          w[4];
        int          wmax;
        bus.req_valid = 4'hf;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        #1;
        chk("rst_req_ready", bus.req_ready, 4'b0000);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id",    bus.rsp_id,    0);
        chk("rst_rsp_sum",   bus.rsp_sum,   0);
        chk("rst_rsp_cout",  bus.rsp_cout,  0);
        cyc();
        rst_n = 1'b1;
        bus.req_valid = 4'b0000;
        cyc();
        chk("idle_rsp_valid", bus.rsp_valid, 0);
        // single request from requester 2
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b1;
        set_op(2, 16'h1234, 16'h1111);
        #1;
        chk("single_ready", bus.req_ready, 4'b0100);
        cyc();
        bus.req_valid = 4'b0000;
        chk("single_valid", bus.rsp_valid, 1);
        chk("single_id",    bus.rsp_id,    2);
        chk("single_sum",   bus.rsp_sum,   16'h2345);
        chk("single_cout",  bus.rsp_cout,  0);
        // overflow from requester 0 (pointer now 3, wraps to 0)
        bus.req_valid = 4'b0001;
        set_op(0, 16'hFFFF, 16'h0001);
        #1;
        chk("ovf_ready", bus.req_ready, 4'b0001);
        cyc();
        bus.req_valid = 4'b0000;
        chk("ovf_sum",  bus.rsp_sum,  16'h0000);
        chk("ovf_cout", bus.rsp_cout, 1);
        chk("ovf_id",   bus.rsp_id,   0);
        // round robin from a fresh pointer
        rst_pulse();
        for (int i = 0; i < 4; i++) set_op(i, 16'h0100 * i + 16'h0001, 16'h0010);
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("rr_valid", bus.rsp_valid, 1);
            chk("rr_id",    bus.rsp_id,    rr_ids[k]);
            chk("rr_sum",   bus.rsp_sum,   rr_sums[k]);
        end
        // backpressure: FULL holding id 0, pointer at 1
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready", bus.req_ready, 4'b0000);
            cyc();
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_id",    bus.rsp_id,    0);
            chk("bp_sum",   bus.rsp_sum,   16'h0011);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", bus.req_ready, 4'b0010);
        cyc();
        chk("bp_next_id",  bus.rsp_id,  1);
        chk("bp_next_sum", bus.rsp_sum, 16'h0111);
        // reset while FULL (pointer at 2, requester 1 found after wrap)
        set_op(1, 16'h0055, 16'h0055);
        bus.req_valid = 4'b0010;
        cyc();
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b0;
        chk("mid_id",  bus.rsp_id,  1);
        chk("mid_sum", bus.rsp_sum, 16'h00AA);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.rsp_valid, 0);
        chk("mid_rst_sum",   bus.rsp_sum,   0);
        chk("mid_rst_id",    bus.rsp_id,    0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_valid", bus.rsp_valid, 0);
        bus.req_valid = 4'b1010;
        bus.rsp_ready = 1'b1;
        #1;
        chk("post_rst_ready", bus.req_ready, 4'b0010);
        cyc();
        bus.req_valid = 4'b0000;
        chk("post_rst_id",    bus.rsp_id,    1);
        chk("post_rst_rvld",  bus.rsp_valid, 1);
        cyc();
        chk("drain_valid", bus.rsp_valid, 0);
        chk("drain_id",    bus.rsp_id,    1);
        chk("drain_sum",   bus.rsp_sum,   16'h00AA);
        // random soak against an operand-level scoreboard
        rst_pulse();
        ev = 1'b0; eid = '0; esum = '0; ecout = 1'b0;
        for (int i = 0; i < 4; i++) w[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            chk("rnd_valid", bus.rsp_valid, ev);
            if (ev) begin
                chk("rnd_id",   bus.rsp_id,   eid);
                chk("rnd_sum",  bus.rsp_sum,  esum);
                chk("rnd_cout", bus.rsp_cout, ecout);
            end
            for (int i = 0; i < 4; i++) begin
                v[i] = $urandom_range(0, 3) != 0;
                set_op(i, 16'($urandom), 16'($urandom));
            end
            bus.req_valid = v;
            bus.rsp_ready = $urandom_range(0, 2) != 0;
            #1;
            rdy = bus.req_ready;
            chk("rnd_legal", 32'((rdy & ~v) == 4'b0 && $onehot0(rdy)), 1);
            chk("rnd_grant", 32'(|rdy), 32'((!ev || bus.rsp_ready) && |v));
            if (|rdy) begin
                gi = rdy[0] ? 2'd0 : rdy[1] ? 2'd1 : rdy[2] ? 2'd2 : 2'd3;
                full = {1'b0, bus.req_a[gi*16 +: 16]} + {1'b0, bus.req_b[gi*16 +: 16]};
                ev = 1'b1; eid = gi; esum = full[15:0]; ecout = full[16];
                for (int i = 0; i < 4; i++) w[i] = (!v[i] || i == int'(gi)) ? 0 : w[i] + 1;
            end else begin
                if (bus.rsp_ready) ev = 1'b0;
                for (int i = 0; i < 4; i++) if (!v[i]) w[i] = 0;
            end
            wmax = 0;
            for (int i = 0; i < 4; i++) if (w[i] > wmax) wmax = w[i];
            chk("rnd_fair", 32'(wmax <= 3), 1);
            cyc();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
